// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the square-wave frequency meter.
package freq_meter_pkg;

    localparam int CNT_W  = 32;
    localparam int FREQ_W = 16;

    localparam logic [FREQ_W-1:0] FREQ_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } meter_state_e;

    // Cycles without a rising edge before the input is declared silent.
    function automatic int timeout_cycles(input int clk_hz, input int min_hz);
        return clk_hz / min_hz;
    endfunction

endpackage

// File: rtl/seq_divider_u32.sv
// Restoring unsigned divider: one load cycle, then one quotient bit per cycle.
// done_o and quotient_o are combinational on the final iteration cycle.
module seq_divider_u32
    import freq_meter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         done_o,
    output logic [W-1:0] quotient_o
);
    localparam int STEP_W = $clog2(W + 1);

    logic [W-1:0]      rem_q, rem_d;
    logic [W-1:0]      quo_q, quo_d;
    logic [W-1:0]      dvs_q, dvs_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              run_q, run_d;
    logic [W:0]        shifted;

    always_comb begin
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        steps_d    = steps_q;
        run_d      = run_q;
        done_o     = 1'b0;
        shifted    = {rem_q, quo_q[W-1]};
        if (abort_i) begin
            run_d = 1'b0;
        end else if (start_i) begin
            rem_d   = '0;
            quo_d   = dividend_i;
            dvs_d   = divisor_i;
            steps_d = STEP_W'(W);
            run_d   = 1'b1;
        end else if (run_q) begin
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = W'(shifted - {1'b0, dvs_q});
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            steps_d = steps_q - STEP_W'(1);
            if (steps_q == STEP_W'(1)) begin
                run_d  = 1'b0;
                done_o = 1'b1;
            end
        end
        quotient_o = quo_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            steps_q <= '0;
            run_q   <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            steps_q <= steps_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/square_wave_freq_meter.sv
// Measures rising-edge period of audio_in and reports CLK_HZ / period in Hz.
//
// state   | meaning
// IDLE    | no reference edge yet; counter held at 0
// MEASURE | counting cycles since the last rising edge
// DIVIDE  | divider converting the captured period into Hz
module square_wave_freq_meter #(
    parameter int CLK_HZ = 50_000_000,
    parameter int MIN_HZ = 20,
    parameter int CNT_W  = freq_meter_pkg::CNT_W
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              audio_in,
    input  logic                              enable,
    output logic [freq_meter_pkg::FREQ_W-1:0] freq_hz,
    output logic                              freq_valid,
    output logic                              silent,
    output logic                              busy
);
    import freq_meter_pkg::*;

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(timeout_cycles(CLK_HZ, MIN_HZ));
    // Decide one cycle early so the silent pulse lands TIMEOUT cycles after the edge.
    localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - CNT_W'(2);

    meter_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              valid_q, valid_d;
    logic              silent_q, silent_d;
    logic              s1_q, s2_q, s3_q;
    logic              rise;
    logic [CNT_W-1:0]  cnt_inc;
    logic              div_start;
    logic              div_done;
    logic [CNT_W-1:0]  div_quot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= audio_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise    = s2_q & ~s3_q;
    assign cnt_inc = (cnt_q < TIMEOUT) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        freq_d    = freq_q;
        valid_d   = 1'b0;
        silent_d  = silent_q;
        div_start = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise) state_d = MEASURE;
                end
                MEASURE: begin
                    if (rise) begin
                        cnt_d     = '0;
                        div_start = 1'b1;
                        state_d   = DIVIDE;
                    end else if (cnt_q >= TO_LAST) begin
                        cnt_d    = '0;
                        freq_d   = '0;
                        silent_d = 1'b1;
                        valid_d  = ~silent_q;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                DIVIDE: begin
                    // Edges here only restart the period; they are not measured.
                    cnt_d = rise ? '0 : cnt_inc;
                    if (div_done) begin
                        freq_d   = (div_quot > CNT_W'(FREQ_SAT)) ? FREQ_SAT : div_quot[FREQ_W-1:0];
                        valid_d  = 1'b1;
                        silent_d = 1'b0;
                        state_d  = MEASURE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            freq_q   <= '0;
            valid_q  <= 1'b0;
            silent_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            freq_q   <= freq_d;
            valid_q  <= valid_d;
            silent_q <= silent_d;
        end
    end

    seq_divider_u32 #(
        .W (CNT_W)
    ) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (div_start),
        .abort_i    (~enable),
        .dividend_i (CNT_W'(CLK_HZ)),
        .divisor_i  (cnt_q + CNT_W'(1)),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    assign freq_hz    = freq_q;
    assign freq_valid = valid_q;
    assign silent     = silent_q;
    assign busy       = (state_q == DIVIDE);

endmodule

// File: tb/tb_square_wave_freq_meter.sv
// Bench for square_wave_freq_meter at a reduced clock rate so timeouts stay short.
module tb_square_wave_freq_meter;

    localparam int CLK_HZ  = 1_000_000;
    localparam int MIN_HZ  = 100;
    localparam int TIMEOUT = CLK_HZ / MIN_HZ;
    localparam int LAT     = 33;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        audio_in = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] freq_hz;
    logic        freq_valid;
    logic        silent;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    square_wave_freq_meter #(
        .CLK_HZ (CLK_HZ),
        .MIN_HZ (MIN_HZ),
        .CNT_W  (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .audio_in   (audio_in),
        .enable     (enable),
        .freq_hz    (freq_hz),
        .freq_valid (freq_valid),
        .silent     (silent),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: expected outputs for the current cycle, derived from edge times.
    logic [15:0] m_freq = '0;
    logic        m_valid = 1'b0;
    logic        m_silent = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_track = 1'b0;
    int          m_due = -1;
    int          m_last = 0;
    logic [15:0] m_due_val = '0;
    logic        h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    int          valid_count = 0;
    int          last_valid_cyc = -1;
    logic [15:0] last_valid_freq = '0;

    always @(negedge clk) begin
        logic r;
        int   per;
        logic nv;
        if (!reset_n) begin
            m_freq = '0; m_valid = 1'b0; m_silent = 1'b1; m_busy = 1'b0;
            m_track = 1'b0; m_due = -1;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end
        check("freq_hz", 32'(freq_hz), 32'(m_freq));
        check("freq_valid", 32'(freq_valid), 32'(m_valid));
        check("silent", 32'(silent), 32'(m_silent));
        check("busy", 32'(busy), 32'(m_busy));
        if (freq_valid === 1'b1) begin
            valid_count++;
            last_valid_cyc  = cyc;
            last_valid_freq = freq_hz;
        end
        if (reset_n) begin
            r  = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = audio_in;
            nv = 1'b0;
            if (!enable) begin
                m_track = 1'b0;
                m_due   = -1;
            end else if (m_due >= 0) begin
                if (r) m_last = cyc;
                if (m_due == cyc + 1) begin
                    m_freq = m_due_val; nv = 1'b1; m_silent = 1'b0; m_due = -1;
                end
            end else if (!m_track) begin
                if (r) begin m_track = 1'b1; m_last = cyc; end
            end else if (r) begin
                per       = cyc - m_last;
                m_due_val = (CLK_HZ / per > 65535) ? 16'hFFFF : 16'(CLK_HZ / per);
                m_due     = cyc + LAT;
                m_last    = cyc;
            end else if (cyc + 1 - m_last >= TIMEOUT) begin
                nv = !m_silent; m_freq = '0; m_silent = 1'b1; m_track = 1'b0;
            end
            m_valid = nv;
            m_busy  = (m_due >= 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo, output int rise_cyc);
        audio_in = 1'b1;
        rise_cyc = cyc;
        repeat (hi) tick();
        audio_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic square(input int per, input int n, output int first_rise, output int last_rise);
        int r;
        first_rise = cyc;
        last_rise  = cyc;
        for (int i = 0; i < n; i++) begin
            pulse(per / 2, per - per / 2, r);
            if (i == 0) first_rise = r;
            last_rise = r;
        end
    endtask

    initial begin
        int r1, rl, rr, vc, per, hi, dummy;
        reset_n = 1'b0; enable = 1'b0; audio_in = 1'b0;
        repeat (3) tick();
        check("rst_freq", 32'(freq_hz), 0);
        check("rst_valid", 32'(freq_valid), 0);
        check("rst_silent", 32'(silent), 1);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1; enable = 1'b1;
        repeat (2) tick();

        // 440 Hz equivalent: period 2272 -> 1e6/2272 = 440
        vc = valid_count;
        square(2272, 2, r1, rl);
        check("t440_count", valid_count - vc, 1);
        check("t440_freq", 32'(last_valid_freq), 440);
        check("t440_latency", last_valid_cyc, r1 + 2272 + 35);
        check("t440_silent", 32'(silent), 0);
        check("t440_busy", 32'(busy), 0);
        square(2272, 2, r1, rl);

        // 262 Hz equivalent: period 3817 -> floor 261, one transitional 440 first
        vc = valid_count;
        square(3817, 4, r1, rl);
        check("t262_count", valid_count - vc, 4);
        check("t262_freq", 32'(last_valid_freq), 261);

        // Silence: single pulse exactly TIMEOUT cycles after the last rise pulse
        vc = valid_count;
        while (cyc < rl + 2 + TIMEOUT + 100) tick();
        check("tsil_count", valid_count - vc, 1);
        check("tsil_when", last_valid_cyc, rl + 2 + TIMEOUT);
        check("tsil_freq", 32'(freq_hz), 0);
        check("tsil_silent", 32'(silent), 1);
        repeat (300) tick();
        check("tsil_quiet", valid_count - vc, 1);

        // Fast input saturates; edges during the divide are skipped
        vc = valid_count;
        square(10, 12, r1, rl);
        check("tsat_count", valid_count - vc, 2);
        check("tsat_freq", 32'(last_valid_freq), 65535);
        check("tsat_silent", 32'(silent), 0);
        repeat (100) tick();

        // Enable dropped: outputs hold, then two rises for a fresh result
        enable = 1'b0;
        vc = valid_count;
        square(1000, 1, r1, rl);
        check("ten_hold_freq", 32'(freq_hz), 65535);
        check("ten_hold_count", valid_count - vc, 0);
        enable = 1'b1;
        square(1000, 2, r1, rl);
        check("ten_count", valid_count - vc, 1);
        check("ten_when", last_valid_cyc, r1 + 1035);
        check("ten_freq", 32'(last_valid_freq), 1000);

        // Reset ten cycles into a divide
        pulse(5, 5, rr);
        repeat (2) tick();
        check("trst_busy_before", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("trst_freq", 32'(freq_hz), 0);
        check("trst_silent", 32'(silent), 1);
        check("trst_busy", 32'(busy), 0);
        check("trst_valid", 32'(freq_valid), 0);
        vc = valid_count;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (40) tick();
        check("trst_no_valid", valid_count - vc, 0);
        square(1000, 2, r1, rl);
        check("trst_count", valid_count - vc, 1);
        check("trst_when", last_valid_cyc, r1 + 1035);
        check("trst_freq2", 32'(last_valid_freq), 1000);

        // Randomized periods, duty cycles and enable gaps against the model
        for (int s = 0; s < 8; s++) begin
            per = $urandom_range(4, 1200);
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 300)) tick();
                enable = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                hi = $urandom_range(1, per - 1);
                pulse(hi, per - hi, dummy);
            end
        end
        repeat (50) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
